// File: rtl/key_matrix_scan.sv
// 4x4 matrix keypad scanner. Columns are driven one-hot low in rotation and
// the active-low rows are sampled at the end of each column slot. A press and
// its release are both debounced. Each accepted press produces a key code
// (row*4 + col) and a one-cycle valid strobe.
module key_matrix_scan #(
  parameter logic [15:0] SCAN_CNT_MAX = 16'd50_000,   // cycles per column slot
  parameter logic [19:0] DB_CNT_MAX   = 20'd1_000_000 // cycles a row level must hold
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    REL_DB
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_meta_q;
  logic [3:0]  row_s_q;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  lat_row_q, lat_row_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_down_q, key_down_d;

  logic [1:0]  low_row;
  logic        row_high;
  logic        end_scan;
  logic        db_done;

  // Two-flop synchronizer for the asynchronous keypad rows.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_meta_q <= 4'b1111;
      row_s_q    <= 4'b1111;
    end else begin
      // NOTE: non-blocking assignments so row_s_q takes the old row_meta_q,
      // giving two real flop stages rather than one collapsed stage.
      row_meta_q <= key_row;
      row_s_q    <= row_meta_q;
    end
  end

  // Lowest-index low row wins when several rows are low together.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_q[i]) low_row = 2'(i);
    end
  end

  // While a key is tracked the column stays frozen, so col_idx_q is also the
  // latched column of that key.
  assign row_high = row_s_q[lat_row_q];
  assign end_scan = (scan_cnt_q == SCAN_CNT_MAX - 16'd1);
  assign db_done  = (db_cnt_q == DB_CNT_MAX - 20'd1);

  // Next-state logic: scan rotation, press debounce, hold, release debounce.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    scan_cnt_d  = '0;
    db_cnt_d    = '0;
    col_idx_d   = col_idx_q;
    lat_row_d   = lat_row_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    unique case (state_q)
      SCAN: begin
        if (end_scan) begin
          if (row_s_q != 4'b1111) begin
            // Column is held on this slot so the press can be debounced.
            lat_row_d = low_row;
            state_d   = PRESS_DB;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 16'd1;
        end
      end

      PRESS_DB: begin
        if (row_high) begin
          // Bounce: abandon this key and continue with the next column.
          state_d   = SCAN;
          col_idx_d = col_idx_q + 2'd1;
        end else if (db_done) begin
          key_code_d  = {lat_row_q, col_idx_q};
          key_valid_d = 1'b1;
          key_down_d  = 1'b1;
          state_d     = HELD;
        end else begin
          db_cnt_d = db_cnt_q + 20'd1;
        end
      end

      HELD: begin
        if (row_high) state_d = REL_DB;
      end

      REL_DB: begin
        if (!row_high) begin
          // Bounce or re-press: still the same held key, no new strobe.
          state_d = HELD;
        end else if (db_done) begin
          key_down_d = 1'b0;
          state_d    = SCAN;
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          db_cnt_d = db_cnt_q + 20'd1;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= SCAN;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      col_idx_q   <= 2'd0;
      lat_row_q   <= 2'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      col_idx_q   <= col_idx_d;
      lat_row_q   <= lat_row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign key_col   = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Testbench for key_matrix_scan with short scan/debounce periods. A small
// keypad model turns a 16-bit "pressed" mask into row levels depending on
// which column is currently driven low.
module tb_key_matrix_scan;

  localparam logic [15:0] K0  = 16'h0001; // row 0, col 0
  localparam logic [15:0] K5  = 16'h0020; // row 1, col 1
  localparam logic [15:0] K6  = 16'h0040; // row 1, col 2
  localparam logic [15:0] K10 = 16'h0400; // row 2, col 2
  localparam logic [15:0] K14 = 16'h4000; // row 3, col 2

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic [15:0] pressed;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [15:0] mask;
    int          cycles;
    logic [3:0]  col;
    logic [3:0]  code;
    logic        down;
    int          valids;
  } vec_t;

  vec_t tbl[$];

  key_matrix_scan #(
    .SCAN_CNT_MAX(16'd10),
    .DB_CNT_MAX  (20'd20)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    key_row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply a key mask for n clock cycles (starting and ending on a falling
  // edge), counting strobes, then compare the visible outputs.
  task automatic step(input string name, input logic [15:0] m, input int n,
                      input logic [3:0] e_col, input logic [3:0] e_code,
                      input logic e_down, input int e_valid);
    int vcnt;
    vcnt = 0;
    pressed = m;
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (key_valid) vcnt++;
    end
    check({name, "/col"},   32'(key_col),  32'(e_col));
    check({name, "/code"},  32'(key_code), 32'(e_code));
    check({name, "/down"},  32'(key_down), 32'(e_down));
    check({name, "/valid"}, 32'(vcnt),     32'(e_valid));
  endtask

  task automatic add_vec(input logic [15:0] m, input int n, input logic [3:0] c,
                         input logic [3:0] code, input logic d, input int v);
    vec_t t;
    t.mask = m; t.cycles = n; t.col = c; t.code = code; t.down = d; t.valids = v;
    tbl.push_back(t);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    pressed = 16'h0000;
    sys_rst_n = 1'b0;

    // Idle rotation, then a clean press/hold/release of key 10.
    add_vec(16'h0,  9, 4'b1110, 4'd0,  1'b0, 0);
    add_vec(16'h0,  1, 4'b1101, 4'd0,  1'b0, 0);
    add_vec(16'h0,  9, 4'b1101, 4'd0,  1'b0, 0);
    add_vec(16'h0,  1, 4'b1011, 4'd0,  1'b0, 0);
    add_vec(16'h0, 10, 4'b0111, 4'd0,  1'b0, 0);
    add_vec(16'h0, 10, 4'b1110, 4'd0,  1'b0, 0);
    add_vec(K10,   29, 4'b1011, 4'd0,  1'b0, 0);
    add_vec(K10,    1, 4'b1011, 4'd0,  1'b0, 0); // latched: no rotation
    add_vec(K10,   19, 4'b1011, 4'd0,  1'b0, 0);
    add_vec(K10,    1, 4'b1011, 4'd10, 1'b1, 1); // accepted
    add_vec(K10,   30, 4'b1011, 4'd10, 1'b1, 0);
    add_vec(16'h0, 22, 4'b1011, 4'd10, 1'b1, 0);
    add_vec(16'h0,  1, 4'b0111, 4'd10, 1'b0, 0); // release accepted
    add_vec(16'h0,  9, 4'b0111, 4'd10, 1'b0, 0);
    add_vec(16'h0,  1, 4'b1110, 4'd10, 1'b0, 0);

    repeat (3) @(negedge sys_clk);
    check("rst/col",   32'(key_col),   32'(4'b1110));
    check("rst/code",  32'(key_code),  32'(4'd0));
    check("rst/valid", 32'(key_valid), 32'(1'b0));
    check("rst/down",  32'(key_down),  32'(1'b0));
    sys_rst_n = 1'b1;

    foreach (tbl[i])
      step($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].cycles, tbl[i].col,
           tbl[i].code, tbl[i].down, tbl[i].valids);

    // Press bounce on key 0: latch, bounce aborts, re-latched a rotation later.
    step("b3a", 16'h0,  3, 4'b1110, 4'd10, 1'b0, 0);
    step("b3b", K0,     5, 4'b1110, 4'd10, 1'b0, 0);
    step("b3c", 16'h0,  3, 4'b1101, 4'd10, 1'b0, 0);
    step("b3d", K0,     5, 4'b1101, 4'd10, 1'b0, 0);
    step("b3e", 16'h0,  3, 4'b1101, 4'd10, 1'b0, 0);
    step("b3f", K0,    32, 4'b1110, 4'd10, 1'b0, 0);
    step("b3g", K0,    19, 4'b1110, 4'd10, 1'b0, 0);
    step("b3h", K0,     1, 4'b1110, 4'd0,  1'b1, 1);
    step("b3i", 16'h0, 22, 4'b1110, 4'd0,  1'b1, 0);
    step("b3j", 16'h0,  1, 4'b1101, 4'd0,  1'b0, 0);

    // Key 5 with re-press glitches inside the release window.
    step("r4a", K5,    29, 4'b1101, 4'd0, 1'b0, 0);
    step("r4b", K5,     1, 4'b1101, 4'd5, 1'b1, 1);
    step("r4c", 16'h0, 10, 4'b1101, 4'd5, 1'b1, 0);
    step("r4d", K5,     4, 4'b1101, 4'd5, 1'b1, 0);
    step("r4e", 16'h0, 10, 4'b1101, 4'd5, 1'b1, 0);
    step("r4f", K5,     4, 4'b1101, 4'd5, 1'b1, 0);
    step("r4g", 16'h0, 22, 4'b1101, 4'd5, 1'b1, 0);
    step("r4h", 16'h0,  1, 4'b1011, 4'd5, 1'b0, 0);

    // Rows 1 and 3 on column 2: row 1 wins, row 3 picked up on a later scan.
    step("m5a", K6 | K14, 29, 4'b1011, 4'd5,  1'b0, 0);
    step("m5b", K6 | K14,  1, 4'b1011, 4'd6,  1'b1, 1);
    step("m5c", K14,      22, 4'b1011, 4'd6,  1'b1, 0);
    step("m5d", K14,       1, 4'b0111, 4'd6,  1'b0, 0);
    step("m5e", K14,      59, 4'b1011, 4'd6,  1'b0, 0);
    step("m5f", K14,       1, 4'b1011, 4'd14, 1'b1, 1);

    // Asynchronous reset while HELD, then scanning restarts.
    #3 sys_rst_n = 1'b0;
    #1;
    check("ar/col",   32'(key_col),   32'(4'b1110));
    check("ar/code",  32'(key_code),  32'(4'd0));
    check("ar/down",  32'(key_down),  32'(1'b0));
    check("ar/valid", 32'(key_valid), 32'(1'b0));
    pressed = 16'h0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("ar/hold_col",   32'(key_col),   32'(4'b1110));
    check("ar/hold_valid", 32'(key_valid), 32'(1'b0));
    sys_rst_n = 1'b1;
    step("ar2a", 16'h0, 9, 4'b1110, 4'd0, 1'b0, 0);
    step("ar2b", 16'h0, 1, 4'b1101, 4'd0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
